// File: rtl/ram_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_scan_reader
// Purpose  : Frame-based multi-channel RAM sweep with latency-matched tagging.
// Revision : 1.0 - initial release
// ============================================================================
module ram_scan_reader #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 10,
    parameter int DEPTH   = 2048,
    parameter int CH_N    = 2,
    parameter int PERIOD  = 500_000,
    parameter int RAM_LAT = 1,
    parameter int CH_W    = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              trig,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_ram,
    output logic [CH_W-1:0]   rd_ch,
    input  logic [DATA_W-1:0] q_ram,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [CH_W-1:0]   dout_ch,
    output logic [ADDR_W-1:0] dout_idx,
    output logic              sof,
    output logic              eof,
    output logic              busy,
    output logic              flag,
    output logic              overrun
);

    localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int DRN_W = $clog2(RAM_LAT + 2);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]   c_LAST_CH   = CH_W'(CH_N - 1);
    localparam logic [TMR_W-1:0]  c_TMR_LAST  = TMR_W'(PERIOD - 1);
    localparam logic [DRN_W-1:0]  c_DRN_LAST  = DRN_W'(RAM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [TMR_W-1:0]   r_timer;
    logic [ADDR_W-1:0]  r_addr;
    logic [CH_W-1:0]    r_ch;
    logic [DRN_W-1:0]   r_drn_cnt;
    logic               w_start;
    logic               w_first;
    logic               w_last;

    logic [RAM_LAT-1:0] r_p_en;
    logic [RAM_LAT-1:0] r_p_first;
    logic [RAM_LAT-1:0] r_p_last;
    logic [CH_W-1:0]    r_p_ch  [RAM_LAT];
    logic [ADDR_W-1:0]  r_p_idx [RAM_LAT];

    // Frame timer; single-shot mode parks it at 0 so a switch back fires at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (mode || (r_timer == c_TMR_LAST)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Gated by rst_n so the tick is low while the block is held in reset.
    assign flag    = rst_n & ~mode & (r_timer == '0);
    assign w_start = mode ? trig : flag;
    assign w_first = (r_addr == '0) && (r_ch == '0);
    assign w_last  = (r_addr == c_LAST_ADDR) && (r_ch == c_LAST_CH);
    assign rd_ram  = r_addr;
    assign rd_ch   = r_ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rd_en        = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_drn_cnt == c_DRN_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address and channel wrap back to 0 on the final word, leaving them 0 in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_ch      <= '0;
            r_drn_cnt <= '0;
        end else begin
            if (r_state == S_READ) begin
                if (r_addr == c_LAST_ADDR) begin
                    r_addr <= '0;
                    r_ch   <= (r_ch == c_LAST_CH) ? '0 : r_ch + CH_W'(1);
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
            if (r_state == S_DRAIN) begin
                r_drn_cnt <= r_drn_cnt + DRN_W'(1);
            end else begin
                r_drn_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_en    <= '0;
            r_p_first <= '0;
            r_p_last  <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                r_p_ch[i]  <= '0;
                r_p_idx[i] <= '0;
            end
        end else begin
            r_p_en[0]    <= rd_en;
            r_p_first[0] <= rd_en & w_first;
            r_p_last[0]  <= rd_en & w_last;
            r_p_ch[0]    <= r_ch;
            r_p_idx[0]   <= r_addr;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_p_en[i]    <= r_p_en[i-1];
                r_p_first[i] <= r_p_first[i-1];
                r_p_last[i]  <= r_p_last[i-1];
                r_p_ch[i]    <= r_p_ch[i-1];
                r_p_idx[i]   <= r_p_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
            dout_idx   <= '0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout_valid <= r_p_en[RAM_LAT-1];
            sof        <= r_p_en[RAM_LAT-1] & r_p_first[RAM_LAT-1];
            eof        <= r_p_en[RAM_LAT-1] & r_p_last[RAM_LAT-1];
            if (r_p_en[RAM_LAT-1]) begin
                dout     <= q_ram;
                dout_ch  <= r_p_ch[RAM_LAT-1];
                dout_idx <= r_p_idx[RAM_LAT-1];
            end
            if (busy && (flag || trig)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_reader.sv
`default_nettype none
// Bench for ram_scan_reader: four instances (LAT 2/1/4 and DEPTH=1) driven by
// a per-cycle vector table plus directed multi-cycle sequences.
module tb_ram_scan_reader;

    localparam int         c_LAT [4] = '{2, 1, 4, 2};
    localparam int         c_DEP [4] = '{8, 8, 8, 1};
    localparam int         c_CHN [4] = '{2, 2, 2, 1};
    localparam int         c_PER [4] = '{64, 64, 64, 8};
    localparam logic [7:0] c_XOR [4] = '{8'h00, 8'h00, 8'h00, 8'h5A};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]      rst_n;
    logic [3:0]      mode;
    logic [3:0]      trig;
    wire  [3:0]      rd_en, rd_ch, dv, dch, sof, eof, busy, flag, ovr;
    wire  [3:0][3:0] rd_ram, didx;
    wire  [3:0][7:0] q, dout;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [7:0] ram_d [4];
        always @(posedge clk) begin
            ram_d[0] <= {3'b000, rd_ch[g], rd_ram[g]} ^ c_XOR[g];
            for (int i = 1; i < 4; i++) ram_d[i] <= ram_d[i-1];
        end
        assign q[g] = ram_d[c_LAT[g]-1];

        ram_scan_reader #(
            .ADDR_W (4),
            .DATA_W (8),
            .DEPTH  (c_DEP[g]),
            .CH_N   (c_CHN[g]),
            .PERIOD (c_PER[g]),
            .RAM_LAT(c_LAT[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .mode      (mode[g]),
            .trig      (trig[g]),
            .rd_en     (rd_en[g]),
            .rd_ram    (rd_ram[g]),
            .rd_ch     (rd_ch[g]),
            .q_ram     (q[g]),
            .dout      (dout[g]),
            .dout_valid(dv[g]),
            .dout_ch   (dch[g]),
            .dout_idx  (didx[g]),
            .sof       (sof[g]),
            .eof       (eof[g]),
            .busy      (busy[g]),
            .flag      (flag[g]),
            .overrun   (ovr[g])
        );
    end

    typedef struct {
        logic        mode;
        logic        trig;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl [86];

    function automatic logic [24:0] vec(input int g);
        return {rd_en[g], rd_ram[g], rd_ch[g], dv[g], dout[g], dch[g], didx[g],
                sof[g], eof[g], busy[g], flag[g], ovr[g]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int         k, j, n_str, n_flag;
        logic       re, rch, v, sf, ef, bz, fl, hc;
        logic [3:0] rr, hi;
        logic [7:0] hd;
        int         f_rd [4], f_dv [4], n_busy [4], fall [4], last_dv [4], n_dv [4];
        int         exp_lag [4], exp_busy [4];

        rst_n = 4'b0000;
        mode  = 4'b1000;
        trig  = 4'b0000;

        // Expected per-cycle outputs of the periodic sweep, cycle 0 = reset release.
        hd = '0; hc = 1'b0; hi = '0;
        for (int c = 0; c < 86; c++) begin
            k = (c >= 1 && c <= 16) ? c - 1 : (c >= 65 && c <= 80) ? c - 65 : -1;
            j = (c >= 4 && c <= 19) ? c - 4 : (c >= 68 && c <= 83) ? c - 68 : -1;
            re = (k >= 0);
            rr = (k >= 0) ? 4'(k % 8) : 4'd0;
            rch = (k >= 8);
            v = (j >= 0); sf = (j == 0); ef = (j == 15);
            if (j >= 0) begin
                hc = (j >= 8);
                hi = 4'(j % 8);
                hd = {3'b000, hc, hi};
            end
            bz = (c >= 1 && c <= 19) || (c >= 65 && c <= 83);
            fl = (c % 64 == 0);
            tbl[c].mode = 1'b0;
            tbl[c].trig = 1'b0;
            tbl[c].exp  = {re, rr, rch, v, hd, hc, hi, sf, ef, bz, fl, 1'b0};
        end

        repeat (3) @(negedge clk);
        #1;
        check("reset state", vec(0), 25'd0);

        // Periodic sweep from the table.
        @(negedge clk);
        rst_n[0] = 1'b1;
        for (int c = 0; c < 86; c++) begin
            if (c > 0) @(negedge clk);
            mode[0] = tbl[c].mode;
            trig[0] = tbl[c].trig;
            #1;
            check($sformatf("periodic c%0d", c), vec(0), tbl[c].exp);
        end

        // Single-shot with an ignored trigger, a restart, then reset at the 6th strobe.
        @(negedge clk);
        rst_n[0] = 1'b0; mode[0] = 1'b1; trig[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        n_str = 0; n_flag = 0;
        for (int c = 0; c <= 28; c++) begin
            if (c > 0) @(negedge clk);
            trig[0] = (c == 2 || c == 7 || c == 22);
            if (c == 28) begin
                rst_n[0] = 1'b0;
                mode[0]  = 1'b0;
                trig[0]  = 1'b0;
            end
            #1;
            if (flag[0]) n_flag++;
            if (rd_en[0] && c >= 3 && c <= 21) n_str++;
            if (c == 3)  check("ss start", {rd_en[0], busy[0], rd_ram[0], rd_ch[0]}, {1'b1, 1'b1, 4'd0, 1'b0});
            if (c == 7)  check("ss overrun pre", ovr[0], 1'b0);
            if (c == 8)  check("ss overrun set", {ovr[0], rd_ram[0]}, {1'b1, 4'd5});
            if (c == 21) check("ss last word", {busy[0], dv[0], eof[0], dout[0]}, {1'b1, 1'b1, 1'b1, 8'h17});
            if (c == 22) check("ss idle", {busy[0], rd_en[0], ovr[0]}, {1'b0, 1'b0, 1'b1});
            if (c == 23) check("ss restart", {rd_en[0], rd_ram[0], busy[0], ovr[0]}, {1'b1, 4'd0, 1'b1, 1'b1});
            if (c == 28) check("reset mid-frame", vec(0), 25'd0);
        end
        check("ss strobe count", n_str, 16);
        check("ss flag count", n_flag, 0);
        @(negedge clk);
        #1;
        check("reset hold", vec(0), 25'd0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        for (int r = 0; r <= 4; r++) begin
            if (r > 0) @(negedge clk);
            #1;
            if (r == 0) check("release flag", {flag[0], dv[0], rd_en[0]}, {1'b1, 1'b0, 1'b0});
            if (r == 1) check("release strobe", {rd_en[0], rd_ram[0], rd_ch[0]}, {1'b1, 4'd0, 1'b0});
            if (r >= 1 && r <= 3) check($sformatf("no stray valid r%0d", r), dv[0], 1'b0);
            if (r == 4) check("release first word", {dv[0], sof[0], dout[0]}, {1'b1, 1'b1, 8'h00});
        end

        // Latency sweep on the RAM_LAT=1 and RAM_LAT=4 instances.
        exp_lag  = '{0, 2, 5, 0};
        exp_busy = '{0, 18, 21, 0};
        for (int g = 0; g < 4; g++) begin
            f_rd[g] = -1; f_dv[g] = -1; fall[g] = -1;
            n_busy[g] = 0; last_dv[g] = -1; n_dv[g] = 0;
        end
        @(negedge clk);
        rst_n[1] = 1'b1;
        rst_n[2] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            for (int g = 1; g <= 2; g++) begin
                if (rd_en[g] && f_rd[g] < 0) f_rd[g] = c;
                if (busy[g]) n_busy[g]++;
                else if (n_busy[g] > 0 && fall[g] < 0) fall[g] = c;
                if (dv[g]) begin
                    if (f_dv[g] < 0) f_dv[g] = c;
                    last_dv[g] = c;
                    hc = (n_dv[g] >= 8);
                    hi = 4'(n_dv[g] % 8);
                    check($sformatf("lat%0d word%0d", c_LAT[g], n_dv[g]),
                          {dout[g], dch[g], didx[g], sof[g], eof[g]},
                          {3'b000, hc, hi, hc, hi, n_dv[g] == 0, n_dv[g] == 15});
                    n_dv[g]++;
                end
            end
        end
        for (int g = 1; g <= 2; g++) begin
            check($sformatf("lat%0d lag", c_LAT[g]), f_dv[g] - f_rd[g], exp_lag[g]);
            check($sformatf("lat%0d busy len", c_LAT[g]), n_busy[g], exp_busy[g]);
            check($sformatf("lat%0d busy fall", c_LAT[g]), fall[g], last_dv[g] + 1);
            check($sformatf("lat%0d word count", c_LAT[g]), n_dv[g], 16);
        end

        // DEPTH=1, CH_N=1 single-shot frame.
        @(negedge clk);
        rst_n[3] = 1'b1;
        n_str = 0; n_flag = 0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            trig[3] = (c == 1);
            #1;
            if (rd_en[3]) n_str++;
            if (flag[3]) n_flag++;
            if (c == 2) check("d1 strobe", {rd_en[3], rd_ram[3], busy[3]}, {1'b1, 4'd0, 1'b1});
            if (c == 3) check("d1 drain", {rd_en[3], busy[3], dv[3]}, {1'b0, 1'b1, 1'b0});
            if (c == 5) check("d1 word", {dv[3], sof[3], eof[3], dout[3]}, {1'b1, 1'b1, 1'b1, 8'h5A});
            if (c == 6) check("d1 idle", {dv[3], sof[3], eof[3], busy[3]}, 4'b0000);
        end
        check("d1 strobe count", n_str, 1);
        check("d1 flag count", n_flag, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
